ioports_host: RTL and testbench

Host-side master for the byte-serial I/O-port protocol used by the 16-output/8-input general-purpose port block. It takes a single-word transaction request (reset, write, or read) from local logic and serialises it onto the 8-bit command/data bus. For reads it runs the `ready`/`enout` byte handshake and reassembles the 32-bit result. It sits between the test/control logic and the port block, which it drives directly.

---
 rtl/ioports_host.sv | 220 ++++++++++++++++++++++
 tb/tb_ioports_host.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ioports_host.sv
// Host master for the byte-serial I/O-port bus: one request word in, command/data bytes out, 32-bit read reassembly.
// Latency: command byte 1 cycle after accept; write done at 6+GAP_CYCLES, port reset at 2+GAP_CYCLES, read at 2+4*4+GAP_CYCLES with a next-cycle responder.
// Backpressure: req ignored (no queue) while busy; reads wait on enout edges, bounded by TIMEOUT_CYCLES only when IOHOST_TIMEOUT_EN is defined.
module ioports_host #(
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [1:0]  req_cmd,
    input  logic [3:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        timeout,
    output logic        load,
    output logic [7:0]  datain,
    output logic        ready,
    input  logic        enout,
    input  logic [7:0]  dataout
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_W3, S_W2, S_W1, S_W0, S_RHI, S_RLO, S_GAP, S_FIN
    } state_t;

    // With a zero gap every path that would enter GAP goes straight to FIN.
    localparam state_t     S_POST   = (GAP_CYCLES == 0) ? S_FIN : S_GAP;
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [1:0]  cmd_q, cmd_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] sh_q, sh_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic [7:0]  gap_q, gap_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        load_q, load_d;
    logic        ready_q, ready_d;
    logic [7:0]  datain_q, datain_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  code;

`ifdef IOHOST_TIMEOUT_EN
    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_q, tmo_d;
    logic        tflag_q, tflag_d;
    logic        timeout_q, timeout_d;
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        wdata_d  = wdata_q;
        sh_d     = sh_q;
        bcnt_d   = bcnt_q;
        gap_d    = gap_q;
        datain_d = datain_q;
        code     = {1'b0, req_cmd} + 3'd1;
`ifdef IOHOST_TIMEOUT_EN
        tmo_d    = TMO_LOAD;
        tflag_d  = tflag_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (req_cmd == 2'b11) begin
                        state_d = S_FIN;
                    end else begin
                        state_d  = S_CMD;
                        cmd_d    = req_cmd;
                        wdata_d  = req_wdata;
                        sh_d     = 32'd0;
                        bcnt_d   = 3'd0;
                        datain_d = {1'b0, code, req_addr};
`ifdef IOHOST_TIMEOUT_EN
                        tflag_d  = 1'b0;
`endif
                    end
                end
            end
            S_CMD: begin
                case (cmd_q)
                    2'b01: begin
                        state_d  = S_W3;
                        datain_d = wdata_q[31:24];
                    end
                    2'b10: state_d = S_RHI;
                    default: begin
                        state_d = S_POST;
                        gap_d   = GAP_LOAD;
                    end
                endcase
            end
            S_W3: begin
                state_d  = S_W2;
                datain_d = wdata_q[23:16];
            end
            S_W2: begin
                state_d  = S_W1;
                datain_d = wdata_q[15:8];
            end
            S_W1: begin
                state_d  = S_W0;
                datain_d = wdata_q[7:0];
            end
            S_W0: begin
                state_d = S_POST;
                gap_d   = GAP_LOAD;
            end
            S_RHI: begin
                if (enout) begin
                    state_d = S_RLO;
                    sh_d    = {sh_q[23:0], dataout};
                    bcnt_d  = bcnt_q + 3'd1;
                end
            end
            S_RLO: begin
                if (!enout) begin
                    if (bcnt_q == 3'd4) begin
                        state_d = S_POST;
                        gap_d   = GAP_LOAD;
                    end else begin
                        state_d = S_RHI;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == 8'd0) state_d = S_FIN;
                else               gap_d   = gap_q - 8'd1;
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

`ifdef IOHOST_TIMEOUT_EN
        // The counter only runs while parked in a read handshake state; any transition reloads it.
        if ((state_q == S_RHI || state_q == S_RLO) && state_d == state_q) begin
            if (tmo_q == 16'd0) begin
                state_d = S_POST;
                gap_d   = GAP_LOAD;
                tflag_d = 1'b1;
            end else begin
                tmo_d = tmo_q - 16'd1;
            end
        end
`endif

        // Outputs are registered from the next state so they line up with the state they describe.
        load_d  = (state_d inside {S_CMD, S_W3, S_W2, S_W1, S_W0});
        ready_d = (state_d == S_RHI);
        done_d  = (state_d == S_FIN);
        busy_d  = !(state_d == S_IDLE || state_d == S_FIN);
        rdata_d = rdata_q;
        if (state_d == S_FIN && state_q != S_IDLE && cmd_q == 2'b10)
            rdata_d = sh_d;
`ifdef IOHOST_TIMEOUT_EN
        timeout_d = (state_d == S_FIN) && tflag_d;
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cmd_q    <= 2'b00;
            wdata_q  <= 32'd0;
            sh_q     <= 32'd0;
            bcnt_q   <= 3'd0;
            gap_q    <= 8'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            load_q   <= 1'b0;
            ready_q  <= 1'b0;
            datain_q <= 8'd0;
            rdata_q  <= 32'd0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            wdata_q  <= wdata_d;
            sh_q     <= sh_d;
            bcnt_q   <= bcnt_d;
            gap_q    <= gap_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            load_q   <= load_d;
            ready_q  <= ready_d;
            datain_q <= datain_d;
            rdata_q  <= rdata_d;
        end
    end

`ifdef IOHOST_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q     <= 16'd0;
            tflag_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            tflag_q   <= tflag_d;
            timeout_q <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign load   = load_q;
    assign ready  = ready_q;
    assign datain = datain_q;
    assign rdata  = rdata_q;

endmodule

// File: tb/tb_ioports_host.sv
// Bench for ioports_host: randomized transactions checked against a cycle/byte-level reference of the bus protocol.
module tb_ioports_host;
    localparam int GAP = 4;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [1:0]  req_cmd;
    logic [3:0]  req_addr;
    logic [31:0] req_wdata;
    logic        busy, done, timeout, load, ready;
    logic [31:0] rdata;
    logic [7:0]  datain;
    logic        enout;
    logic [7:0]  dataout;

    ioports_host #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
        .req_wdata(req_wdata), .busy(busy), .done(done), .rdata(rdata), .timeout(timeout),
        .load(load), .datain(datain), .ready(ready), .enout(enout), .dataout(dataout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]  load_b[$];
    int          load_c[$];
    int          r_done, r_nready, r_readyhi, r_busybad;
    logic        r_timeout;
    logic [31:0] r_rdata;
    logic        ab_seen, ab_busy, ab_ready, ab_load, ab_done;
    logic [31:0] ab_rdata;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] cmd_byte(input int code, input logic [3:0] addr);
        return 8'(code * 16 + int'(addr));
    endfunction

    // Issues one request and plays the port block: enout follows ready one cycle late, bytes MSB first.
    task automatic drive_txn(input logic [1:0] cmd, input logic [3:0] addr, input logic [31:0] wd,
                             input logic [31:0] rword, input bit stuck, input int abort_at);
        int   k;
        int   falls;
        logic prev;
        logic en_new;
        load_b.delete();
        load_c.delete();
        r_done = -1; r_nready = 0; r_readyhi = 0; r_busybad = 0;
        r_timeout = 1'bx; r_rdata = 'x; ab_seen = 1'b0;
        k = 0; falls = 0; prev = 1'b0;
        req = 1'b1; req_cmd = cmd; req_addr = addr; req_wdata = wd;
        tick();
        req = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (load) begin
                load_b.push_back(datain);
                load_c.push_back(c);
            end
            if (ready && !prev) r_nready++;
            if (ready) r_readyhi++;
            if (!ready && prev) falls++;
            if (done) begin
                r_done = c; r_timeout = timeout; r_rdata = rdata;
                if (busy !== 1'b0) r_busybad++;
                break;
            end
            if (busy !== (cmd != 2'b11)) r_busybad++;
            if (abort_at > 0 && falls == abort_at) begin
                reset = 1'b1;
                #1;
                ab_busy = busy; ab_ready = ready; ab_load = load; ab_done = done; ab_rdata = rdata;
                ab_seen = 1'b1;
                enout = 1'b0; dataout = 8'd0;
                tick();
                tick();
                reset = 1'b0;
                break;
            end
            en_new = stuck ? 1'b0 : prev;
            if (en_new && !enout && k < 4) begin
                dataout = rword[31 - 8*k -: 8];
                k++;
            end
            enout = en_new;
            prev = ready;
            tick();
        end
        enout = 1'b0;
        dataout = 8'd0;
        tick();
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 1'b0; req_cmd = 2'b00; req_addr = 4'd0; req_wdata = 32'd0;
        enout = 1'b0; dataout = 8'd0;
        tick(); tick();
        tests++; if (busy !== 1'b0)     begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0)     begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (load !== 1'b0)     begin fails++; $display("FAIL reset_load: got %b want 0", load); end
        tests++; if (ready !== 1'b0)    begin fails++; $display("FAIL reset_ready: got %b want 0", ready); end
        tests++; if (timeout !== 1'b0)  begin fails++; $display("FAIL reset_timeout: got %b want 0", timeout); end
        tests++; if (datain !== 8'd0)   begin fails++; $display("FAIL reset_datain: got %h want 00", datain); end
        tests++; if (rdata !== 32'd0)   begin fails++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        reset = 1'b0;
        tick();
        tests++; if (busy !== 1'b0 || load !== 1'b0) begin
            fails++; $display("FAIL idle_after_reset: busy %b load %b want 0 0", busy, load);
        end
    endtask

    task automatic test_write;
        logic [3:0]  a;
        logic [31:0] d;
        logic [7:0]  exp_b[5];
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 4'd3 : 4'($urandom_range(15, 0));
            d = (i == 0) ? 32'hDEADBEEF : $urandom;
            exp_b[0] = cmd_byte(2, a);
            for (int j = 0; j < 4; j++) exp_b[j+1] = d[31 - 8*j -: 8];
            drive_txn(2'b01, a, d, 32'd0, 1'b0, 0);
            tests++;
            if (load_b.size() != 5) begin
                fails++; $display("FAIL write_nloads: got %0d want 5", load_b.size());
            end else begin
                for (int j = 0; j < 5; j++) begin
                    tests++;
                    if (load_b[j] !== exp_b[j] || load_c[j] != j + 1) begin
                        fails++;
                        $display("FAIL write_byte%0d: got %h@%0d want %h@%0d", j, load_b[j], load_c[j], exp_b[j], j + 1);
                    end
                end
            end
            tests++; if (r_done != 6 + GAP) begin fails++; $display("FAIL write_done_cycle: got %0d want %0d", r_done, 6 + GAP); end
            tests++; if (r_busybad != 0)    begin fails++; $display("FAIL write_busy: %0d bad cycles want 0", r_busybad); end
            tests++; if (r_timeout !== 1'b0) begin fails++; $display("FAIL write_timeout: got %b want 0", r_timeout); end
        end
    endtask

    task automatic test_read;
        logic [3:0]  a;
        logic [31:0] w;
        for (int i = 0; i < 3; i++) begin
            a = (i == 0) ? 4'd5 : 4'($urandom_range(15, 0));
            w = (i == 0) ? 32'h12345678 : $urandom;
            drive_txn(2'b10, a, 32'd0, w, 1'b0, 0);
            tests++;
            if (load_b.size() != 1 || load_b[0] !== cmd_byte(3, a) || load_c[0] != 1) begin
                fails++; $display("FAIL read_cmd: %0d loads, first %h want single %h at cycle 1",
                                  load_b.size(), (load_b.size() > 0) ? load_b[0] : 8'hxx, cmd_byte(3, a));
            end
            tests++; if (r_nready != 4)       begin fails++; $display("FAIL read_ready_pulses: got %0d want 4", r_nready); end
            tests++; if (r_rdata !== w)        begin fails++; $display("FAIL read_rdata: got %h want %h", r_rdata, w); end
            tests++; if (r_timeout !== 1'b0)   begin fails++; $display("FAIL read_timeout: got %b want 0", r_timeout); end
            tests++; if (r_done != 2 + 16 + GAP) begin fails++; $display("FAIL read_done_cycle: got %0d want %0d", r_done, 18 + GAP); end
            tests++; if (r_busybad != 0)      begin fails++; $display("FAIL read_busy: %0d bad cycles want 0", r_busybad); end
            drive_txn(2'b01, 4'($urandom_range(15, 0)), $urandom, 32'd0, 1'b0, 0);
            tests++; if (rdata !== w) begin fails++; $display("FAIL read_rdata_hold: got %h want %h", rdata, w); end
        end
    endtask

    task automatic test_port_reset;
        logic [3:0] a;
        for (int i = 0; i < 2; i++) begin
            a = (i == 0) ? 4'd0 : 4'($urandom_range(15, 1));
            drive_txn(2'b00, a, $urandom, 32'd0, 1'b0, 0);
            tests++;
            if (load_b.size() != 1 || load_b[0] !== cmd_byte(1, a)) begin
                fails++; $display("FAIL preset_cmd: %0d loads, first %h want single %h",
                                  load_b.size(), (load_b.size() > 0) ? load_b[0] : 8'hxx, cmd_byte(1, a));
            end
            tests++; if (r_done != 2 + GAP) begin fails++; $display("FAIL preset_done_cycle: got %0d want %0d", r_done, 2 + GAP); end
            tests++; if (r_busybad != 0)    begin fails++; $display("FAIL preset_busy: %0d bad cycles want 0", r_busybad); end
        end
    endtask

    task automatic test_reserved;
        drive_txn(2'b11, 4'($urandom_range(15, 0)), $urandom, 32'd0, 1'b0, 0);
        tests++; if (r_done != 1)          begin fails++; $display("FAIL rsvd_done_cycle: got %0d want 1", r_done); end
        tests++; if (r_busybad != 0)       begin fails++; $display("FAIL rsvd_busy: %0d busy cycles want 0", r_busybad); end
        tests++; if (load_b.size() != 0)   begin fails++; $display("FAIL rsvd_loads: got %0d want 0", load_b.size()); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w2;
        int sec_c, first_done, ndone, nl;
        w2 = $urandom;
        sec_c = -1; first_done = -1; ndone = 0;
        load_b.delete();
        load_c.delete();
        req = 1'b1; req_cmd = 2'b01; req_addr = 4'd15; req_wdata = 32'h00000001;
        tick();
        req_addr = 4'd0; req_wdata = w2;
        for (int c = 1; c <= 200; c++) begin
            if (load) begin
                load_b.push_back(datain);
                load_c.push_back(c);
                if (datain == 8'h20 && sec_c < 0) begin
                    sec_c = c;
                    req = 1'b0;
                end
            end
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = c;
                if (ndone == 2) break;
            end
            tick();
        end
        req = 1'b0;
        tick();
        nl = load_b.size();
        tests++; if (ndone != 2) begin fails++; $display("FAIL b2b_ndone: got %0d want 2", ndone); end
        tests++; if (nl != 10)   begin fails++; $display("FAIL b2b_nloads: got %0d want 10", nl); end
        if (nl == 10) begin
            tests++;
            if (load_b[0] !== 8'h2F || load_b[4] !== 8'h01) begin
                fails++; $display("FAIL b2b_first: got %h/%h want 2f/01", load_b[0], load_b[4]);
            end
            tests++;
            if (sec_c - load_c[4] < 2 + GAP) begin
                fails++; $display("FAIL b2b_spacing: got %0d want >= %0d", sec_c - load_c[4], 2 + GAP);
            end
            tests++;
            if (sec_c <= first_done) begin
                fails++; $display("FAIL b2b_ignored_busy: second cmd at %0d, first done %0d", sec_c, first_done);
            end
            for (int j = 0; j < 4; j++) begin
                tests++;
                if (load_b[6 + j] !== w2[31 - 8*j -: 8]) begin
                    fails++; $display("FAIL b2b_data%0d: got %h want %h", j, load_b[6 + j], w2[31 - 8*j -: 8]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] w;
        drive_txn(2'b10, 4'($urandom_range(15, 0)), 32'd0, $urandom | 32'h1, 1'b0, 2);
        tests++; if (ab_seen !== 1'b1) begin fails++; $display("FAIL mid_reset_reached: got %b want 1", ab_seen); end
        tests++;
        if (ab_busy !== 1'b0 || ab_ready !== 1'b0 || ab_load !== 1'b0 || ab_done !== 1'b0) begin
            fails++; $display("FAIL mid_reset_ctrl: busy %b ready %b load %b done %b want 0000", ab_busy, ab_ready, ab_load, ab_done);
        end
        tests++; if (ab_rdata !== 32'd0) begin fails++; $display("FAIL mid_reset_rdata: got %h want 0", ab_rdata); end
        w = $urandom;
        drive_txn(2'b10, 4'($urandom_range(15, 0)), 32'd0, w, 1'b0, 0);
        tests++; if (r_rdata !== w)    begin fails++; $display("FAIL post_reset_rdata: got %h want %h", r_rdata, w); end
        tests++; if (r_nready != 4)    begin fails++; $display("FAIL post_reset_pulses: got %0d want 4", r_nready); end
        tests++; if (r_done != 18 + GAP) begin fails++; $display("FAIL post_reset_done: got %0d want %0d", r_done, 18 + GAP); end
    endtask

`ifdef IOHOST_TIMEOUT_EN
    task automatic test_timeout;
        drive_txn(2'b10, 4'd7, 32'd0, 32'hA5A5A5A5, 1'b1, 0);
        tests++; if (r_readyhi != TMO)  begin fails++; $display("FAIL tmo_ready_len: got %0d want %0d", r_readyhi, TMO); end
        tests++; if (r_nready != 1)     begin fails++; $display("FAIL tmo_ready_pulses: got %0d want 1", r_nready); end
        tests++; if (r_timeout !== 1'b1) begin fails++; $display("FAIL tmo_flag: got %b want 1", r_timeout); end
        tests++; if (r_done != 2 + TMO + GAP) begin fails++; $display("FAIL tmo_done: got %0d want %0d", r_done, 2 + TMO + GAP); end
        tests++; if (r_rdata !== 32'd0) begin fails++; $display("FAIL tmo_rdata: got %h want 0", r_rdata); end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read();
        test_port_reset();
        test_reserved();
        test_back_to_back();
        test_reset_mid();
`ifdef IOHOST_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
